// File: rtl/tensor_operand_loader.sv
// Streams 32 bytes into two 4x4 operand matrices (A then B), pulses the tensor core start,
// then waits for completion. Optional macro TENSOR_LOADER_TRANSPOSE_EN loads B column-major.
//
// state     | meaning
// LOAD_A    | accepting bytes 0..15 into matrix A (row-major)
// LOAD_B    | accepting bytes 16..31 into matrix B
// FIRE      | one-cycle write_enable pulse to the tensor core
// WAIT_DONE | guard window ignoring done, then wait for is_done_with_calculation
module tensor_operand_loader #(
  parameter int unsigned GUARD_CYCLES = 1
) (
  input  logic                 clock_in,
  input  logic                 reset_in,
  input  logic [7:0]           data_in,
  input  logic                 data_valid_in,
  output logic                 data_ready_out,
  input  logic                 abort_in,
  output logic [3:0][3:0][7:0] tensor_core_input1,
  output logic [3:0][3:0][7:0] tensor_core_input2,
  output logic                 tensor_core_register_file_write_enable,
  input  logic                 is_done_with_calculation,
  output logic                 busy_out,
  output logic [5:0]           byte_index_out
);
  typedef enum logic [1:0] {
    LOAD_A    = 2'd0,
    LOAD_B    = 2'd1,
    FIRE      = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  localparam logic [2:0] GUARD_INIT = 3'(GUARD_CYCLES);

  state_e               state_q;
  logic [5:0]           idx_q;
  logic [2:0]           guard_q;
  logic                 we_q;
  logic                 ready_q;
  logic                 busy_q;
  logic [3:0][3:0][7:0] mat_a_q;
  logic [3:0][3:0][7:0] mat_b_q;

  logic       accept;
  logic [3:0] pos;
  logic [1:0] row_b;
  logic [1:0] col_b;

  assign accept = data_valid_in && ready_q && !abort_in;
  // Position within the matrix currently being filled; idx 16..31 maps to 0..15 for B.
  assign pos    = idx_q[3:0];

`ifdef TENSOR_LOADER_TRANSPOSE_EN
  assign row_b = pos[1:0];
  assign col_b = pos[3:2];
`else
  assign row_b = pos[3:2];
  assign col_b = pos[1:0];
`endif

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= LOAD_A;
      idx_q   <= '0;
      guard_q <= '0;
      we_q    <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      mat_a_q <= '0;
      mat_b_q <= '0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        LOAD_A, LOAD_B: begin
          if (abort_in) begin
            state_q <= LOAD_A;
            idx_q   <= '0;
          end else if (accept) begin
            idx_q <= idx_q + 6'd1;
            if (state_q == LOAD_A) mat_a_q[pos[3:2]][pos[1:0]] <= data_in;
            else                   mat_b_q[row_b][col_b]       <= data_in;
            if (pos == 4'd15) begin
              if (state_q == LOAD_A) begin
                state_q <= LOAD_B;
              end else begin
                state_q <= FIRE;
                we_q    <= 1'b1;
                busy_q  <= 1'b1;
                ready_q <= 1'b0;
              end
            end
          end
        end
        FIRE: begin
          state_q <= WAIT_DONE;
          guard_q <= GUARD_INIT;
        end
        WAIT_DONE: begin
          if (guard_q != 3'd0) begin
            guard_q <= guard_q - 3'd1;
          end else if (is_done_with_calculation) begin
            state_q <= LOAD_A;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: state_q <= LOAD_A;
      endcase
    end
  end

  assign data_ready_out                         = ready_q;
  assign busy_out                               = busy_q;
  assign tensor_core_register_file_write_enable = we_q;
  assign byte_index_out                         = idx_q;
  assign tensor_core_input1                     = mat_a_q;
  assign tensor_core_input2                     = mat_b_q;

endmodule

// File: doc/tensor_operand_loader.md
TENSOR_OPERAND_LOADER -- requirements
Module: tensor_operand_loader

Interface
REQ-001 Parameter GUARD_CYCLES, default 1: WAIT_DONE cycles during which is_done_with_calculation is ignored; legal range 1..7.
REQ-002 clock_in  input  1  single clock; all state updates on posedge.
REQ-003 reset_in  input  1  asynchronous, active-high reset.
REQ-004 data_in  input  8  operand byte stream.
REQ-005 data_valid_in  input  1  data_in valid this cycle.
REQ-006 data_ready_out  output  1  loader accepts a byte this cycle.
REQ-007 abort_in  input  1  synchronous discard of the partial load.
REQ-008 tensor_core_input1  output  8 x [4][4]  matrix A to the tensor core.
REQ-009 tensor_core_input2  output  8 x [4][4]  matrix B to the tensor core.
REQ-010 tensor_core_register_file_write_enable  output  1  one-cycle start pulse to the tensor core.
REQ-011 is_done_with_calculation  input  1  tensor core completion flag.
REQ-012 busy_out  output  1  high in FIRE and WAIT_DONE.
REQ-013 byte_index_out  output  6  accepted bytes in the current load, 0..32.

Function
REQ-014 A byte SHALL be accepted on a posedge where data_valid_in && data_ready_out; data_ready_out is high only in LOAD_A and LOAD_B.
REQ-015 The states SHALL be LOAD_A, LOAD_B, FIRE and WAIT_DONE, encoded in 2 bits.
REQ-016 In LOAD_A, byte n (0..15) SHALL be written to tensor_core_input1[n/4][n%4], row-major; the 16th acceptance moves to LOAD_B.
REQ-017 In LOAD_B, byte n (16..31) SHALL be written to tensor_core_input2[(n-16)/4][(n-16)%4]; the 32nd acceptance moves to FIRE.
REQ-018 In FIRE, tensor_core_register_file_write_enable SHALL be high for exactly one cycle; the next state is WAIT_DONE.
REQ-019 From the edge accepting byte 31 to write_enable high, latency SHALL be 1 cycle.
REQ-020 WAIT_DONE SHALL ignore is_done_with_calculation for GUARD_CYCLES cycles, using a 3-bit guard counter, then return to LOAD_A on the first cycle it samples 1.
REQ-021 On return to LOAD_A, byte_index_out SHALL clear to 0; data_ready_out is high in the following cycle.
REQ-022 Both matrix outputs SHALL hold stable from FIRE until WAIT_DONE exits, and change only on accepted bytes.
REQ-023 Loading a new A SHALL leave the previous B contents in place until overwritten.
REQ-024 abort_in in LOAD_A or LOAD_B SHALL return the FSM to LOAD_A with byte_index_out = 0; a byte offered in the same cycle is not accepted; matrix contents are retained.
REQ-025 abort_in in FIRE or WAIT_DONE SHALL be ignored.
REQ-026 data_valid_in while data_ready_out is low SHALL have no effect; the byte is not consumed.
REQ-027 byte_index_out SHALL saturate at 32 in FIRE and WAIT_DONE and never wrap.

Reset
REQ-028 Asserting reset_in SHALL, immediately and asynchronously, set: state LOAD_A, byte_index_out 0, guard counter 0, write_enable 0, busy_out 0, data_ready_out 1, all matrix entries 8'h00.
REQ-029 Reset during WAIT_DONE SHALL abandon the calculation with no write_enable pulse after release.

Configuration
REQ-030 Macro TENSOR_LOADER_TRANSPOSE_EN: when defined, LOAD_B byte n SHALL be written to tensor_core_input2[(n-16)%4][(n-16)/4] (column-major B stream); when undefined, REQ-017 row-major order applies; all other behaviour is identical.

Verification
REQ-031 After reset, stream bytes 1..32 with valid held high -> ready high for 32 cycles; input1[0][0]=1, input1[3][3]=16, input2[0][1]=18; write_enable high exactly one cycle, the cycle after byte 32.
REQ-032 Hold done=1 through FIRE, then assert done 5 cycles after FIRE -> stays in WAIT_DONE during the guard, exits on the first sampled done=1, ready high the next cycle, busy_out falls.
REQ-033 Accept 20 bytes, pulse abort_in with valid high -> byte_index_out=0, offered byte not consumed, input1 retains its values, next byte lands in input1[0][0].
REQ-034 Toggle valid randomly during the load; drive valid high throughout WAIT_DONE -> no byte consumed while ready is low; matrices unchanged until the next LOAD_A.
REQ-035 Assert reset_in mid-WAIT_DONE between clock edges -> outputs reach reset values before the next posedge; no write_enable pulse follows.
REQ-036 With TENSOR_LOADER_TRANSPOSE_EN defined, stream bytes 1..32 -> input2[1][0]=18 and input2[0][1]=21.
